v_store_sequencer: RTL and testbench
====================================

V_STORE_SEQUENCER -- requirements
Module: v_store_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128, giving the bits per vector register.
REQ-002 SHALL have parameter ADDR_W, default `DATAMEM_BITS, giving the data-memory word-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: store request present.
REQ-006 SHALL have port req_ready, output, 1 bit: sequencer can accept a request.
REQ-007 SHALL have ports store_op (input, 4 bits), lmul (input, 3 bits), vsew (input, 3 bits) and stride (input, 5 bits): the store descriptor, with v_pkg VLSU_* opcode encodings.
REQ-008 SHALL have port base_addr, input, ADDR_W bits: first word address.
REQ-009 SHALL have port vdata, input, 512 bits: source register group; element 0 is in the LSBs.
REQ-010 SHALL have port mem_gnt, input, 1 bit: the bank arbiter grants the current beat.
REQ-011 SHALL have ports bank_addr0..bank_addr3, each output, ADDR_W bits: per-bank word address.
REQ-012 SHALL have ports bank_wdata0..bank_wdata3, each output, 32 bits: per-bank write data.
REQ-013 SHALL have port bank_we, output, 4 bits: per-bank write enable; bit i is bank i.
REQ-014 SHALL have port busy (output, 1 bit), high in states ISSUE and DONE.
REQ-015 SHALL have ports done (output, 1 bit), a one-cycle completion pulse, and bad_op (output, 1 bit), valid only while done=1.

Function
REQ-016 SHALL implement states IDLE, ISSUE and DONE; req_ready=1 only in IDLE.
REQ-017 SHALL, on req_valid&&req_ready, latch store_op, lmul, vsew, stride, base_addr and vdata; later input changes SHALL NOT affect the operation.
REQ-018 SHALL, on acceptance, go to ISSUE if the opcode is one of VSE8/16/32 or VSSE8/16/32, else go to DONE with bad_op=1 and perform no writes.
REQ-019 SHALL compute the element size SEW: vsew 000 gives 8, 001 gives 16, 010 gives 32, and any other value gives 32.
REQ-020 SHALL compute the register count NREG: lmul 000 gives 1, 001 gives 2, 010 gives 4, and any other value gives 1.
REQ-021 SHALL compute the beat count N = (VLEN/SEW/4)*NREG, a range of 1 to 16, held in a 5-bit counter.
REQ-022 SHALL take the width for slicing from the opcode (8/16/32), not from vsew.
REQ-023 SHALL, in ISSUE, drive bank_we=4'hF; in all other states bank_we=0.
REQ-024 SHALL, at beat k (0..N-1), make element i (0..3) the bits [(4k+i)*W +: W] of the latched vdata, sign-extended to 32 bits, on bank_wdata i.
REQ-025 SHALL drive bank_addr i = cur_addr + i for unit-stride ops (VSE*) and cur_addr + i*stride for strided ops (VSSE*), with stride as an unsigned word count.
REQ-026 SHALL set cur_addr = base_addr at beat 0 and, per granted beat, advance it by 4 (unit-stride) or 4*stride (strided).
REQ-027 SHALL compute all address arithmetic modulo 2^ADDR_W, wrapping silently.
REQ-028 SHALL advance a beat only on a clock edge where mem_gnt=1; while mem_gnt=0 the addresses, data and bank_we SHALL hold unchanged.
REQ-029 SHALL, on a granted final beat (k=N-1), go to DONE; DONE lasts exactly one cycle with done=1, then the block returns to IDLE.
REQ-030 SHALL give, with mem_gnt held at 1, accept at edge 0, ISSUE in cycles 1..N, and done in cycle N+1; this is the latency.
REQ-031 SHALL NOT let a request presented during DONE be accepted until the following IDLE cycle.
REQ-032 SHALL treat stride=0 on a strided op as legal: all four banks get the same address on every beat.

Reset
REQ-033 SHALL, while nrst=0, immediately (asynchronously) force state IDLE, counters=0, cur_addr=0, bank_we=0, done=0, bad_op=0, busy=0, req_ready=1, bank_addr*=0 and bank_wdata*=0.
REQ-034 SHALL, on reset during ISSUE, abandon the operation with no further writes and no done pulse.

Verification
REQ-035 SHALL cover: VSE32, vsew=010, lmul=000, base=0x100, gnt=1 -> 1 beat at addresses 0x100..0x103 with data vdata[127:0] split into words, done in cycle 2.
REQ-036 SHALL cover: VSE8, vsew=000, lmul=001, base=0x10 -> 8 beats; beat 0 addresses 0x10..0x13; beat 7 addresses 0x2C..0x2F; byte 0x80 written as 0xFFFFFF80.
REQ-037 SHALL cover: VSSE16, vsew=001, lmul=000, stride=3, base=0x20 -> beat 0 addresses 0x20/0x23/0x26/0x29; beat 1 addresses 0x2C/0x2F/0x32/0x35; done after 2 beats.
REQ-038 SHALL cover: mem_gnt low for 3 cycles mid-operation -> outputs frozen and completion delayed by exactly 3 cycles; also base=2^ADDR_W-2 -> addresses wrap to 0 and 1.
REQ-039 SHALL cover: store_op not a valid store op -> no bank_we, done=1 with bad_op=1 in cycle 1.
REQ-040 SHALL cover: nrst asserted asynchronously at beat 2 of 4 -> bank_we drops before the next edge, no done, and a new request is accepted after release.

Source files
------------

// File: rtl/v_store_sequencer.sv
// rtl/v_store_sequencer.sv - vector unit/strided store sequencer, four bank writes per beat
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 16
`endif

module v_store_sequencer #(
  parameter int VLEN   = 128,
  parameter int ADDR_W = `DATAMEM_BITS
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        store_op,
  input  logic [2:0]        lmul,
  input  logic [2:0]        vsew,
  input  logic [4:0]        stride,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [511:0]      vdata,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] bank_addr0,
  output logic [ADDR_W-1:0] bank_addr1,
  output logic [ADDR_W-1:0] bank_addr2,
  output logic [ADDR_W-1:0] bank_addr3,
  output logic [31:0]       bank_wdata0,
  output logic [31:0]       bank_wdata1,
  output logic [31:0]       bank_wdata2,
  output logic [31:0]       bank_wdata3,
  output logic [3:0]        bank_we,
  output logic              busy,
  output logic              done,
  output logic              bad_op
);
  localparam logic [3:0] VLSU_VSE8   = 4'h8;
  localparam logic [3:0] VLSU_VSE16  = 4'h9;
  localparam logic [3:0] VLSU_VSE32  = 4'hA;
  localparam logic [3:0] VLSU_VSSE8  = 4'hC;
  localparam logic [3:0] VLSU_VSSE16 = 4'hD;
  localparam logic [3:0] VLSU_VSSE32 = 4'hE;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;

  logic [1:0]        wsel_q;
  logic              strided_q;
  logic [4:0]        stride_q;
  logic [511:0]      vdata_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        beat;
  logic [4:0]        last_beat;

  // wsel: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit elements; idx = 4*beat + lane
  function automatic logic [31:0] elem(input logic [511:0] d, input logic [1:0] wsel,
                                       input logic [5:0] idx);
    logic [7:0]  b8;
    logic [15:0] b16;
    case (wsel)
      2'd0: begin b8 = 8'(d >> {idx, 3'b000}); elem = {{24{b8[7]}}, b8}; end
      2'd1: begin b16 = 16'(d >> {idx, 4'b0000}); elem = {{16{b16[15]}}, b16}; end
      default: elem = 32'(d >> {idx, 5'b00000});
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] a, input logic str,
                                                  input logic [4:0] s, input logic [1:0] lane);
    logic [6:0] off;
    off = str ? 7'(s) * 7'(lane) : 7'(lane);
    lane_addr = a + ADDR_W'(off);
  endfunction

  logic       op_ok, op_str;
  logic [1:0] op_wsel, lmul_sh;
  logic [4:0] bpr, n_beats;

  always_comb begin
    op_ok   = 1'b1;
    op_str  = 1'b0;
    op_wsel = 2'd2;
    case (store_op)
      VLSU_VSE8:   op_wsel = 2'd0;
      VLSU_VSE16:  op_wsel = 2'd1;
      VLSU_VSE32:  op_wsel = 2'd2;
      VLSU_VSSE8:  begin op_str = 1'b1; op_wsel = 2'd0; end
      VLSU_VSSE16: begin op_str = 1'b1; op_wsel = 2'd1; end
      VLSU_VSSE32: begin op_str = 1'b1; op_wsel = 2'd2; end
      default:     op_ok = 1'b0;
    endcase
    case (vsew)
      3'b000:  bpr = 5'(VLEN / 32);
      3'b001:  bpr = 5'(VLEN / 64);
      default: bpr = 5'(VLEN / 128);
    endcase
    case (lmul)
      3'b001:  lmul_sh = 2'd1;
      3'b010:  lmul_sh = 2'd2;
      default: lmul_sh = 2'd0;
    endcase
    n_beats = bpr << lmul_sh;
  end

  // Outputs for the next beat come from the live inputs on accept, otherwise from latched state
  logic [ADDR_W-1:0] src_addr;
  logic              src_str;
  logic [4:0]        src_stride;
  logic [511:0]      src_data;
  logic [1:0]        src_wsel;
  logic [3:0]        src_beat;
  logic [6:0]        step;
  logic [ADDR_W-1:0] nxt_addr [4];
  logic [31:0]       nxt_data [4];

  always_comb begin
    step = strided_q ? {stride_q, 2'b00} : 7'd4;
    if (state == IDLE) begin
      src_addr   = base_addr;
      src_str    = op_str;
      src_stride = stride;
      src_data   = vdata;
      src_wsel   = op_wsel;
      src_beat   = 4'd0;
    end else begin
      src_addr   = cur_addr + ADDR_W'(step);
      src_str    = strided_q;
      src_stride = stride_q;
      src_data   = vdata_q;
      src_wsel   = wsel_q;
      src_beat   = beat[3:0] + 4'd1;
    end
    for (int i = 0; i < 4; i++) begin
      nxt_addr[i] = lane_addr(src_addr, src_str, src_stride, 2'(i));
      nxt_data[i] = elem(src_data, src_wsel, {src_beat, 2'(i)});
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      bad_op      <= 1'b0;
      bank_we     <= 4'h0;
      beat        <= 5'd0;
      last_beat   <= 5'd0;
      cur_addr    <= '0;
      wsel_q      <= 2'd0;
      strided_q   <= 1'b0;
      stride_q    <= 5'd0;
      vdata_q     <= '0;
      bank_addr0  <= '0;
      bank_addr1  <= '0;
      bank_addr2  <= '0;
      bank_addr3  <= '0;
      bank_wdata0 <= '0;
      bank_wdata1 <= '0;
      bank_wdata2 <= '0;
      bank_wdata3 <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wsel_q    <= op_wsel;
          strided_q <= op_str;
          stride_q  <= stride;
          vdata_q   <= vdata;
          cur_addr  <= base_addr;
          beat      <= 5'd0;
          last_beat <= n_beats - 5'd1;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (op_ok) begin
            state       <= ISSUE;
            bank_we     <= 4'hF;
            bank_addr0  <= nxt_addr[0];
            bank_addr1  <= nxt_addr[1];
            bank_addr2  <= nxt_addr[2];
            bank_addr3  <= nxt_addr[3];
            bank_wdata0 <= nxt_data[0];
            bank_wdata1 <= nxt_data[1];
            bank_wdata2 <= nxt_data[2];
            bank_wdata3 <= nxt_data[3];
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            bad_op <= 1'b1;
          end
        end
        ISSUE: if (mem_gnt) begin
          if (beat == last_beat) begin
            state   <= DONE;
            bank_we <= 4'h0;
            done    <= 1'b1;
          end else begin
            beat        <= beat + 5'd1;
            cur_addr    <= src_addr;
            bank_addr0  <= nxt_addr[0];
            bank_addr1  <= nxt_addr[1];
            bank_addr2  <= nxt_addr[2];
            bank_addr3  <= nxt_addr[3];
            bank_wdata0 <= nxt_data[0];
            bank_wdata1 <= nxt_data[1];
            bank_wdata2 <= nxt_data[2];
            bank_wdata3 <= nxt_data[3];
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          bad_op    <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_v_store_sequencer.sv
// tb/tb_v_store_sequencer.sv - directed self-checking bench for v_store_sequencer
`timescale 1ns/1ps
module tb_v_store_sequencer;
  localparam int AW = 16;
  localparam logic [3:0] OP_VSE8   = 4'h8;
  localparam logic [3:0] OP_VSE32  = 4'hA;
  localparam logic [3:0] OP_VSSE16 = 4'hD;
  localparam logic [3:0] OP_BAD    = 4'h3;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    store_op = 4'h0;
  logic [2:0]    lmul = 3'b000;
  logic [2:0]    vsew = 3'b000;
  logic [4:0]    stride = 5'd0;
  logic [AW-1:0] base_addr = '0;
  logic [511:0]  vdata = '0;
  logic          mem_gnt = 1'b1;
  logic [AW-1:0] bank_addr0, bank_addr1, bank_addr2, bank_addr3;
  logic [31:0]   bank_wdata0, bank_wdata1, bank_wdata2, bank_wdata3;
  logic [3:0]    bank_we;
  logic          busy, done, bad_op;
  logic [511:0]  vd;
  int            n_checks = 0;
  int            n_fail = 0;

  v_store_sequencer #(.VLEN(128), .ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .store_op(store_op), .lmul(lmul), .vsew(vsew), .stride(stride),
    .base_addr(base_addr), .vdata(vdata), .mem_gnt(mem_gnt),
    .bank_addr0(bank_addr0), .bank_addr1(bank_addr1),
    .bank_addr2(bank_addr2), .bank_addr3(bank_addr3),
    .bank_wdata0(bank_wdata0), .bank_wdata1(bank_wdata1),
    .bank_wdata2(bank_wdata2), .bank_wdata3(bank_wdata3),
    .bank_we(bank_we), .busy(busy), .done(done), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] lm, input logic [2:0] sew,
                       input logic [4:0] str, input logic [AW-1:0] base, input logic [511:0] d);
    store_op = op; lmul = lm; vsew = sew; stride = str; base_addr = base; vdata = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_beat(input string t, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    check({t, "_we"}, bank_we, 4'hF);
    check({t, "_a0"}, bank_addr0, a0);
    check({t, "_a1"}, bank_addr1, a1);
    check({t, "_a2"}, bank_addr2, a2);
    check({t, "_a3"}, bank_addr3, a3);
    check({t, "_d0"}, bank_wdata0, d0);
    check({t, "_d1"}, bank_wdata1, d1);
    check({t, "_d2"}, bank_wdata2, d2);
    check({t, "_d3"}, bank_wdata3, d3);
  endtask

  initial begin
    #1 nrst = 1'b0;
    #2;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bad", bad_op, 0);
    check("rst_we", bank_we, 0);
    check("rst_a0", bank_addr0, 0);
    check("rst_d3", bank_wdata3, 0);
    @(negedge clk);
    nrst = 1'b1;
    step(1);

    // VSE32, one beat
    vd = '0;
    vd[127:0] = {32'h8765_4321, 32'hDEAD_BEEF, 32'h0000_0002, 32'h1234_5678};
    issue(OP_VSE32, 3'b000, 3'b010, 5'd0, 16'h0100, vd);
    check_beat("vse32_b0", 16'h0100, 16'h0101, 16'h0102, 16'h0103,
               32'h1234_5678, 32'h0000_0002, 32'hDEAD_BEEF, 32'h8765_4321);
    check("vse32_busy", busy, 1);
    check("vse32_ready", req_ready, 0);
    check("vse32_done_c1", done, 0);
    step(1);
    check("vse32_done_c2", done, 1);
    check("vse32_bad", bad_op, 0);
    check("vse32_we_c2", bank_we, 0);
    step(1);
    check("vse32_done_c3", done, 0);
    check("vse32_ready_c3", req_ready, 1);
    check("vse32_busy_c3", busy, 0);

    // VSE8, lmul=2: 8 beats, inputs scrambled after accept
    vd = '0;
    for (int j = 0; j < 64; j++) vd[j*8 +: 8] = 8'(j);
    vd[7:0] = 8'h80;
    vd[247:240] = 8'hF0;
    issue(OP_VSE8, 3'b001, 3'b000, 5'd0, 16'h0010, vd);
    vdata = '1; base_addr = 16'h7777; store_op = OP_BAD; lmul = 3'b000;
    check_beat("vse8_b0", 16'h0010, 16'h0011, 16'h0012, 16'h0013,
               32'hFFFF_FF80, 32'h1, 32'h2, 32'h3);
    step(7);
    check_beat("vse8_b7", 16'h002C, 16'h002D, 16'h002E, 16'h002F,
               32'h1C, 32'h1D, 32'hFFFF_FFF0, 32'h1F);
    check("vse8_done_c8", done, 0);
    step(1);
    check("vse8_done_c9", done, 1);
    check("vse8_we_c9", bank_we, 0);
    step(1);

    // VSSE16, stride 3, 2 beats
    vd = '0;
    vd[15:0]   = 16'h8001;
    vd[95:80]  = 16'h1234;
    vd[111:96] = 16'h7FFF;
    issue(OP_VSSE16, 3'b000, 3'b001, 5'd3, 16'h0020, vd);
    check_beat("vsse_b0", 16'h0020, 16'h0023, 16'h0026, 16'h0029,
               32'hFFFF_8001, 32'h0, 32'h0, 32'h0);
    step(1);
    check_beat("vsse_b1", 16'h002C, 16'h002F, 16'h0032, 16'h0035,
               32'h0, 32'h1234, 32'h7FFF, 32'h0);
    step(1);
    check("vsse_done", done, 1);
    step(1);

    // VSE32 lmul=4 with address wrap and a 3-cycle grant stall
    vd = '0;
    vd[63:32]   = 32'hFFFF_FFFF;
    vd[159:128] = 32'hCAFE_0004;
    vd[415:384] = 32'h0BAD_000C;
    issue(OP_VSE32, 3'b010, 3'b010, 5'd0, 16'hFFFE, vd);
    check_beat("wrap_b0", 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
               32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step(1);
    check_beat("wrap_b1", 16'h0002, 16'h0003, 16'h0004, 16'h0005,
               32'hCAFE_0004, 32'h0, 32'h0, 32'h0);
    mem_gnt = 1'b0;
    step(1);
    check_beat("stall_c3", 16'h0002, 16'h0003, 16'h0004, 16'h0005,
               32'hCAFE_0004, 32'h0, 32'h0, 32'h0);
    step(2);
    check_beat("stall_c5", 16'h0002, 16'h0003, 16'h0004, 16'h0005,
               32'hCAFE_0004, 32'h0, 32'h0, 32'h0);
    check("stall_done_c5", done, 0);
    mem_gnt = 1'b1;
    step(1);
    check("stall_b2_a0", bank_addr0, 16'h0006);
    step(1);
    check("stall_b3_a0", bank_addr0, 16'h000A);
    check("stall_b3_d0", bank_wdata0, 32'h0BAD_000C);
    check("stall_done_c7", done, 0);
    step(1);
    check("stall_done_c8", done, 1);
    step(1);

    // invalid opcode, request held through DONE
    store_op = OP_BAD; lmul = 3'b000; vsew = 3'b010; base_addr = 16'h0300;
    vd = '0; vd[31:0] = 32'h55; vdata = vd;
    req_valid = 1'b1;
    step(1);
    check("bad_done", done, 1);
    check("bad_flag", bad_op, 1);
    check("bad_we", bank_we, 0);
    check("bad_ready", req_ready, 0);
    store_op = OP_VSE32;
    step(1);
    check("hold_busy_c2", busy, 0);
    check("hold_ready_c2", req_ready, 1);
    check("hold_we_c2", bank_we, 0);
    check("hold_done_c2", done, 0);
    step(1);
    req_valid = 1'b0;
    check("hold_we_c3", bank_we, 4'hF);
    check("hold_a0_c3", bank_addr0, 16'h0300);
    check("hold_d0_c3", bank_wdata0, 32'h55);
    step(1);
    check("hold_done_c4", done, 1);
    check("hold_bad_c4", bad_op, 0);
    step(1);

    // asynchronous reset during beat 2 of 4
    vd = '0;
    vd[31:0]    = 32'h77;
    vd[287:256] = 32'h108;
    issue(OP_VSE32, 3'b010, 3'b010, 5'd0, 16'h0040, vd);
    step(2);
    check("arst_b2_a0", bank_addr0, 16'h0048);
    check("arst_b2_d0", bank_wdata0, 32'h108);
    #2 nrst = 1'b0;
    #1;
    check("arst_we", bank_we, 0);
    check("arst_busy", busy, 0);
    check("arst_a0", bank_addr0, 0);
    check("arst_d0", bank_wdata0, 0);
    check("arst_ready", req_ready, 1);
    @(negedge clk);
    nrst = 1'b1;
    step(1);
    check("arst_no_done", done, 0);
    check("arst_no_we", bank_we, 0);
    issue(OP_VSE32, 3'b000, 3'b010, 5'd0, 16'h0100, vd);
    check_beat("arst_new_b0", 16'h0100, 16'h0101, 16'h0102, 16'h0103,
               32'h77, 32'h0, 32'h0, 32'h0);
    step(1);
    check("arst_new_done", done, 1);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
